conv_frame_collector: RTL
=========================

Name: conv_frame_collector

Overview:
Sink-side companion to convolve. Captures the valid output pixel stream of one frame (output_valid/img_output) into an internal frame buffer, clamping each signed result to an unsigned 8-bit pixel. Once the frame is complete, drains it in raster order over a valid/ready stream toward the readout path (wishbone/flash writer). Sits directly downstream of convolve in the user project.

Parameters:
BITS, 9, width of convolve output samples (two's complement).
KERNEL_SIZE, 3, kernel edge length; sets output frame size.
IMG_LENGTH, 16, input image edge length.
OUT_BITS, 8, output pixel width; must equal BITS-1.
(derived localparams) OUT_LENGTH = IMG_LENGTH-KERNEL_SIZE+1 (14); NPIX = OUT_LENGTH^2 (196); AW = clog2(NPIX).

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  connects to convolve output_valid.
in_data  in  BITS  connects to convolve img_output; signed.
out_valid  out  1  drain data valid.
out_ready  in  1  downstream accept.
out_data  out  OUT_BITS  clamped pixel at read pointer.
out_last  out  1  high with the final pixel (index NPIX-1) of the frame.
frame_done  out  1  one-cycle pulse when the buffer fills.
overflow  out  1  sticky; set when in_valid arrives while not in FILL.
frame_count  out  8  number of fully drained frames; wraps at 255->0.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset values: state=FILL, wr_ptr=0, rd_ptr=0, out_valid=0, out_last=0, frame_done=0, overflow=0, frame_count=0. Buffer contents are not cleared.
- Clamp rule: negative in_data (MSB=1) is written as 0x00. Otherwise the low OUT_BITS bits are written. Example: 9'h1F0 -> 8'h00, 9'h0FF -> 8'hFF.
- FILL state:
  - out_valid=0.
  - On in_valid: mem[wr_ptr] <= clamp(in_data); wr_ptr++.
  - On the write where wr_ptr==NPIX-1: wr_ptr <= 0, state <= DRAIN, and frame_done pulses high for the next cycle only.
- DRAIN state:
  - out_valid=1; out_data=mem[rd_ptr] (combinational read of the register array); out_last=(rd_ptr==NPIX-1).
  - A transfer occurs when out_valid and out_ready are both high; each transfer increments rd_ptr.
  - With out_ready=0, out_data and out_last hold stable.
  - On the transfer with out_last=1: rd_ptr <= 0, frame_count++, state <= FILL. The next in_valid may be accepted in the cycle after that transfer.
- Overflow: in_valid while in DRAIN is dropped (no write, no pointer change) and sets overflow. overflow stays set until reset.
- First-pixel latency: an input written at edge t is readable at rd index 0 in DRAIN no earlier than the cycle after the filling write.
- Reset mid-operation: reset asserted in any state returns all registers to reset values on the next edge. A partial frame is abandoned; the next frame starts at wr_ptr=0.
- Simultaneous events: in_valid in the same cycle as the final DRAIN transfer is dropped and flagged as overflow, because the state is still DRAIN in that cycle.

Decomposition:
- Shared package conv_pkg:
  - BITS, KERNEL_SIZE and IMG_LENGTH defaults.
  - A function computing OUT_LENGTH/NPIX.
  - Collector state enum {FILL, DRAIN}.
- One sub-module: frame_ram (NPIX x OUT_BITS register array; single write port, combinational read port).
- The clamp stays inline.

Test Plan:
1. Fill with in_data=i for i=0..195 back-to-back, out_ready=1 -> frame_done pulses one cycle after the 196th write; drain emits 0x00..0xC3 in order; out_last only on 0xC3; frame_count=1.
2. Clamp: samples 9'h1F0, 9'h100, 9'h0FF, 9'h000 at indices 0..3, rest 0x05 -> drained 0x00, 0x00, 0xFF, 0x00, then 0x05 x192.
3. Backpressure: during drain toggle out_ready 1,0,0,1 repeatedly -> no pixel duplicated or skipped; out_data stable while out_ready=0; 196 transfers total.
4. Overflow: a full frame, then in_valid=1 with 9'h011 during drain -> overflow=1 and stays set; drained frame is unchanged; next frame still starts at index 0.
5. Reset mid-drain after 50 transfers -> out_valid=0, frame_count=0, overflow=0; a new 196-pixel frame drains correctly from index 0.
6. Integration: convolve with identity kernel (center=1) on img1.hex -> drained frame equals the interior 14x14 of the input image; frame_count=1.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared convolve geometry defaults, frame-size helpers and collector state type
package conv_pkg;
    localparam int BITS        = 9;
    localparam int KERNEL_SIZE = 3;
    localparam int IMG_LENGTH  = 16;

    typedef enum logic {FILL, DRAIN} coll_state_e;

    function automatic int out_length(input int img_length, input int kernel_size);
        return img_length - kernel_size + 1;
    endfunction

    function automatic int npix(input int img_length, input int kernel_size);
        return out_length(img_length, kernel_size) * out_length(img_length, kernel_size);
    endfunction
endpackage

// File: rtl/frame_ram.sv
// frame_ram: DEPTH x W register array, one synchronous write port, one combinational read port
//   clk     : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : mem[raddr_i], combinational
module frame_ram #(
    parameter int DEPTH = 196,
    parameter int W     = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/conv_frame_collector.sv
// conv_frame_collector: captures one convolve output frame, clamps to unsigned pixels, drains it in raster order
//   clk, reset  : clock, synchronous active-high reset
//   in_valid    : convolve output_valid
//   in_data     : convolve img_output (signed)
//   out_valid   : drain data valid
//   out_ready   : downstream accept
//   out_data    : clamped pixel at read pointer
//   out_last    : final pixel of the frame
//   frame_done  : one-cycle pulse after the buffer fills
//   overflow    : sticky, input arrived outside FILL
//   frame_count : fully drained frames, wrapping
module conv_frame_collector
    import conv_pkg::*;
#(
    parameter int BITS        = conv_pkg::BITS,
    parameter int KERNEL_SIZE = conv_pkg::KERNEL_SIZE,
    parameter int IMG_LENGTH  = conv_pkg::IMG_LENGTH,
    parameter int OUT_BITS    = BITS - 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [BITS-1:0]     in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_BITS-1:0] out_data,
    output logic                out_last,
    output logic                frame_done,
    output logic                overflow,
    output logic [7:0]          frame_count
);
    localparam int NPIX = npix(IMG_LENGTH, KERNEL_SIZE);
    localparam int AW   = $clog2(NPIX);

    coll_state_e   state_q, state_d;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic          frame_done_q, overflow_q;
    logic [7:0]    frame_count_q;
    logic          wr_en, wr_last, rd_last, xfer;
    logic [OUT_BITS-1:0] clamped;

    assign wr_en   = in_valid && state_q == FILL;
    assign wr_last = wr_en && wr_ptr_q == AW'(NPIX - 1);
    assign rd_last = rd_ptr_q == AW'(NPIX - 1);
    assign xfer    = out_valid && out_ready;
    // Negative results saturate to black; non-negative ones fit in OUT_BITS
    assign clamped = in_data[BITS-1] ? '0 : in_data[OUT_BITS-1:0];

    always_ff @(posedge clk) begin
        if (reset) state_q <= FILL;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q == FILL ? (wr_last ? DRAIN : FILL)
                                  : (xfer && rd_last ? FILL : DRAIN);
    end

    always_comb begin
        out_valid = state_q == DRAIN;
        out_last  = out_valid && rd_last;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            frame_done_q  <= 1'b0;
            overflow_q    <= 1'b0;
            frame_count_q <= '0;
        end else begin
            frame_done_q <= wr_last;
            if (wr_en) wr_ptr_q <= wr_last ? '0 : wr_ptr_q + AW'(1);
            if (xfer) rd_ptr_q <= rd_last ? '0 : rd_ptr_q + AW'(1);
            if (xfer && rd_last) frame_count_q <= frame_count_q + 8'd1;
            if (in_valid && state_q == DRAIN) overflow_q <= 1'b1;
        end
    end

    frame_ram #(.DEPTH(NPIX), .W(OUT_BITS), .AW(AW)) u_ram (
        .clk    (clk),
        .we_i   (wr_en),
        .waddr_i(wr_ptr_q),
        .wdata_i(clamped),
        .raddr_i(rd_ptr_q),
        .rdata_o(out_data)
    );

    assign frame_done  = frame_done_q;
    assign overflow    = overflow_q;
    assign frame_count = frame_count_q;
endmodule
